// File: rtl/if_id_skid_buffer.sv
// rtl/if_id_skid_buffer.sv - two-entry IF/ID elastic register with skid slot and flush
module if_id_skid_buffer #(
    parameter int                DATA_W   = 32,
    parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_instr,
    input  logic [DATA_W-1:0] in_nextpc,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_instr,
    output logic [DATA_W-1:0] out_nextpc,
    output logic [DATA_W-1:0] out_pc
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] main_instr_q, main_instr_d;
    logic [DATA_W-1:0] main_nextpc_q, main_nextpc_d;
    logic [DATA_W-1:0] skid_instr_q, skid_instr_d;
    logic [DATA_W-1:0] skid_nextpc_q, skid_nextpc_d;

    logic accept;
    logic consume;

    // in_ready comes from registered state only, so decode stall never ripples back to fetch combinationally
    assign in_ready  = (state_q != ST_FULL);
    assign out_valid = (state_q != ST_EMPTY);
    assign accept    = in_valid && in_ready;
    assign consume   = out_valid && out_ready;

    always_comb begin
        state_d       = state_q;
        main_instr_d  = main_instr_q;
        main_nextpc_d = main_nextpc_q;
        skid_instr_d  = skid_instr_q;
        skid_nextpc_d = skid_nextpc_q;

        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        main_instr_d  = in_instr;
                        main_nextpc_d = in_nextpc;
                        state_d       = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept && consume) begin
                        main_instr_d  = in_instr;
                        main_nextpc_d = in_nextpc;
                    end else if (accept) begin
                        skid_instr_d  = in_instr;
                        skid_nextpc_d = in_nextpc;
                        state_d       = ST_FULL;
                    end else if (consume) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (consume) begin
                        main_instr_d  = skid_instr_q;
                        main_nextpc_d = skid_nextpc_q;
                        state_d       = ST_ONE;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_EMPTY;
            main_instr_q  <= '0;
            main_nextpc_q <= '0;
            skid_instr_q  <= '0;
            skid_nextpc_q <= '0;
        end else begin
            state_q       <= state_d;
            main_instr_q  <= main_instr_d;
            main_nextpc_q <= main_nextpc_d;
            skid_instr_q  <= skid_instr_d;
            skid_nextpc_q <= skid_nextpc_d;
        end
    end

    assign out_instr  = out_valid ? main_instr_q : NOP_WORD;
    assign out_nextpc = main_nextpc_q;
    // Wraps modulo 2^DATA_W, so a next-PC of zero reports the top word address
    assign out_pc     = main_nextpc_q - DATA_W'(4);

endmodule

// File: tb/tb_if_id_skid_buffer.sv
// tb/tb_if_id_skid_buffer.sv - scoreboard testbench for if_id_skid_buffer
module tb_if_id_skid_buffer;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] nextpc;
        logic [31:0] pc;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_nextpc;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_nextpc;
    logic [31:0] out_pc;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    if_id_skid_buffer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_instr   (in_instr),
        .in_nextpc  (in_nextpc),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_instr  (out_instr),
        .out_nextpc (out_nextpc),
        .out_pc     (out_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares every word decode actually takes against the scoreboard head
    always @(negedge clk) begin
        if (rst_n) begin
            if (!out_valid) begin
                check("nop_when_invalid", out_instr, 32'h0000_0000);
            end else if (out_ready) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_output: got instr %h expected no word at %0t", out_instr, $time);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("out_instr", out_instr, e.instr);
                    check("out_nextpc", out_nextpc, e.nextpc);
                    check("out_pc", out_pc, e.pc);
                end
            end
        end
    end

    // Called one time unit after a rising edge; returns one time unit after the next one
    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] npc,
                         input logic [31:0] epc, input logic ordy, input logic fl);
        exp_t e;
        in_valid  = v;
        in_instr  = ins;
        in_nextpc = npc;
        out_ready = ordy;
        flush     = fl;
        if (v && in_ready && !fl) begin
            e.instr  = ins;
            e.nextpc = npc;
            e.pc     = epc;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        if (fl) sb.delete();
    endtask

    task automatic idle(input logic ordy);
        drive(1'b0, 32'h0, 32'h0, 32'h0, ordy, 1'b0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = '0;
        in_nextpc = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("rst_out_instr", out_instr, 32'h0000_0000);
        check("rst_out_nextpc", out_nextpc, 32'h0000_0000);
        check("rst_out_pc", out_pc, 32'hFFFF_FFFC);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Streaming with decode always ready
        drive(1'b1, 32'h2008_0001, 32'h0000_0004, 32'h0000_0000, 1'b1, 1'b0);
        check("latency_out_valid", {31'b0, out_valid}, 32'd1);
        check("latency_out_instr", out_instr, 32'h2008_0001);
        drive(1'b1, 32'h2009_0002, 32'h0000_0008, 32'h0000_0004, 1'b1, 1'b0);
        check("stream_out_instr2", out_instr, 32'h2009_0002);
        drive(1'b1, 32'h012A_4020, 32'h0000_000C, 32'h0000_0008, 1'b1, 1'b0);
        check("stream_out_instr3", out_instr, 32'h012A_4020);
        idle(1'b1);
        check("stream_drained", {31'b0, out_valid}, 32'd0);

        // Back-pressure fills the skid slot
        drive(1'b1, 32'hAAAA_0001, 32'h0000_0104, 32'h0000_0100, 1'b0, 1'b0);
        drive(1'b1, 32'hBBBB_0002, 32'h0000_0108, 32'h0000_0104, 1'b0, 1'b0);
        check("full_in_ready", {31'b0, in_ready}, 32'd0);
        check("full_out_instr", out_instr, 32'hAAAA_0001);
        drive(1'b1, 32'hDEAD_BEEF, 32'h0000_0DEC, 32'h0, 1'b0, 1'b0);
        check("full_hold_instr", out_instr, 32'hAAAA_0001);
        idle(1'b1);
        check("full_consume_in_ready", {31'b0, in_ready}, 32'd1);
        check("full_consume_skid", out_instr, 32'hBBBB_0002);
        idle(1'b1);
        check("bp_drained", {31'b0, out_valid}, 32'd0);

        // Flush while full, decode ready in the same cycle
        drive(1'b1, 32'hA2A2_0001, 32'h0000_0204, 32'h0000_0200, 1'b0, 1'b0);
        drive(1'b1, 32'hB2B2_0002, 32'h0000_0208, 32'h0000_0204, 1'b0, 1'b0);
        drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1);
        check("flush_out_valid", {31'b0, out_valid}, 32'd0);
        check("flush_out_instr", out_instr, 32'h0000_0000);
        check("flush_in_ready", {31'b0, in_ready}, 32'd1);
        drive(1'b1, 32'hCCCC_0003, 32'h0000_0304, 32'h0000_0300, 1'b1, 1'b0);
        check("post_flush_first", out_instr, 32'hCCCC_0003);
        idle(1'b1);

        // Accept and consume in the same cycle keeps the buffer at one entry
        drive(1'b1, 32'h1000_00FF, 32'h0000_0400, 32'h0000_03FC, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 32'h1000_0000 + i, 32'h0000_0404 + 4 * i, 32'h0000_0400 + 4 * i, 1'b1, 1'b0);
            check("one_in_ready", {31'b0, in_ready}, 32'd1);
            check("one_out_valid", {31'b0, out_valid}, 32'd1);
        end
        idle(1'b1);
        check("one_drained", {31'b0, out_valid}, 32'd0);

        // PC wrap at next-PC zero
        drive(1'b1, 32'h0000_0013, 32'h0000_0000, 32'hFFFF_FFFC, 1'b0, 1'b0);
        check("wrap_out_pc", out_pc, 32'hFFFF_FFFC);
        idle(1'b1);
        check("scoreboard_empty", sb.size(), 32'd0);

        // Asynchronous reset in the middle of a cycle while full
        drive(1'b1, 32'hE0E0_0001, 32'h0000_0504, 32'h0000_0500, 1'b0, 1'b0);
        drive(1'b1, 32'hF0F0_0002, 32'h0000_0508, 32'h0000_0504, 1'b0, 1'b0);
        check("pre_reset_in_ready", {31'b0, in_ready}, 32'd0);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("async_rst_out_nextpc", out_nextpc, 32'h0000_0000);
        check("async_rst_in_ready", {31'b0, in_ready}, 32'd1);
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1'b1);
        check("post_reset_out_valid", {31'b0, out_valid}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/if_id_skid_buffer.md
# if_id_skid_buffer

Two-entry elastic pipeline register between the instruction-fetch stage and the decode stage. It captures each fetched instruction word with its next-PC value and presents them to decode under a valid/ready handshake. It absorbs one cycle of decode back-pressure without dropping a fetch, and discards all buffered fetches on a branch/jump flush.

## Interface
- `DATA_W`, default 32: width of the instruction word and of the PC values.
- `NOP_WORD`, default 32'h0000_0000: value driven on `out_instr` whenever `out_valid` is 0.

Ports:
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: fetch presents a word this cycle.
- `in_ready` output 1: buffer can accept a word; registered.
- `in_instr` input DATA_W: fetched instruction.
- `in_nextpc` input DATA_W: PC+4 of the fetched instruction.
- `flush` input 1: discard all buffered and incoming words.
- `out_valid` output 1: decode word available.
- `out_ready` input 1: decode consumes the word this cycle.
- `out_instr` output DATA_W: instruction to decode.
- `out_nextpc` output DATA_W: PC+4 of `out_instr`.
- `out_pc` output DATA_W: PC of `out_instr`, equal to `out_nextpc - 4`.

## Operation
- Storage: a main register that drives the outputs and a skid register. Each holds the pair {instr, nextpc}.
- State machine with three states:
  - EMPTY: no entries.
  - ONE: main register valid.
  - FULL: main and skid registers valid.
- An accept happens when `in_valid && in_ready`. A consume happens when `out_valid && out_ready`.
- Transitions from EMPTY:
  - accept: load main, go to ONE.
  - otherwise: stay in EMPTY.
- Transitions from ONE:
  - accept and consume: overwrite main with the input, stay in ONE.
  - accept only: load skid, go to FULL.
  - consume only: go to EMPTY.
  - neither: hold.
- Transitions from FULL:
  - consume: copy skid to main, go to ONE.
  - otherwise: hold. No accept is possible because `in_ready` is 0.
- `flush` has the highest priority. The next state is EMPTY regardless of accept or consume in that cycle. A word accepted in the flush cycle is discarded. `in_ready` returns to 1 on the next cycle.
- Words leave in arrival order; none are duplicated or dropped except by `flush`.
- Output decode:
  - `out_valid` = (state != EMPTY).
  - `in_ready` = (state != FULL), derived from registered state only. There is no combinational path from `out_ready` to `in_ready`.
  - `out_instr` = main instruction when valid, otherwise `NOP_WORD`.
  - `out_pc` = `out_nextpc - 4`, computed modulo 2^DATA_W (wraps). Example: `out_nextpc` = 0 gives `out_pc` = 32'hFFFF_FFFC.
- Data registers load only on the transitions above. They hold their value otherwise, including while `in_valid` is low.

## Timing
- Reset (`rst_n` low, asynchronous) sets:
  - state = EMPTY, `out_valid` = 0, `in_ready` = 1;
  - `out_instr` = `NOP_WORD`, `out_nextpc` = 0, `out_pc` = 32'hFFFF_FFFC;
  - skid contents = 0.
- Reset asserted mid-operation discards all entries immediately, without waiting for a clock edge. Deassertion takes effect at the next rising edge.
- Latency: a word accepted at edge N is visible on the outputs after edge N, i.e. in cycle N+1. There is no combinational input-to-output path.
- Throughput: one word per cycle in steady state when `out_ready` is held at 1.
- After a consume in FULL, `in_ready` rises in the following cycle.
- `flush` is sampled at the clock edge. `out_valid` is 0 in the cycle after flush.

## Test plan
- Reset, then stream `in_instr` = 0x20080001, 0x20090002, 0x012A4020 with `in_nextpc` = 0x4, 0x8, 0xC and `out_ready` = 1 -> the same three words appear on consecutive cycles starting one cycle after each accept. `out_pc` = 0x0, 0x4, 0x8.
- Hold `out_ready` = 0 and offer words A and B -> both are accepted, state is FULL, and `in_ready` = 0 in the cycle after B. Raise `out_ready` -> A then B are output, and `in_ready` returns to 1.
- In FULL, assert `flush` together with `out_ready` = 1 -> next cycle `out_valid` = 0, `out_instr` = 0x00000000, `in_ready` = 1. A later word C is output as the first entry.
- In ONE, perform a simultaneous accept and consume for 10 cycles -> the state stays ONE, the output sequence matches the input sequence exactly, and `in_ready` stays 1.
- Offer `in_nextpc` = 0x00000000 -> `out_pc` = 0xFFFFFFFC. Assert `rst_n` = 0 between clock edges while in FULL -> `out_valid` and `out_nextpc` go to 0 immediately, and `in_ready` goes to 1.
